// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package bus_arbiter_pkg;

  // Widths inherited from the core's register and instruction-address buses.
  localparam int REG_BUS_W       = 32;
  localparam int INST_ADDR_BUS_W = 32;

  // Instruction fetches always read a full word.
  localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

  // Width of the no-acknowledge watchdog counter.
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_MEM_BUSY = 2'd1,
    ARB_IF_BUSY  = 2'd2,
    ARB_IF_DROP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_timeout_cnt.sv
// Watchdog counter for one bus transaction: counts enabled cycles and flags
// the cycle in which the count would reach the limit (limit 0 disables it).
module bus_timeout_cnt
  import bus_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 hit
);

  logic [TIMEOUT_W-1:0] cnt_reg;
  logic [TIMEOUT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_reg} + (TIMEOUT_W+1)'(1);
  assign hit     = en && (limit != '0) && (cnt_inc == {1'b0, limit});

  // Count waiting cycles; clearing has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_inc[TIMEOUT_W-1:0];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the
// MEM stage (MEM has fixed priority), with registered bus outputs, per-master
// stall requests, fetch flush and a no-acknowledge timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = INST_ADDR_BUS_W,
  parameter int DATA_W      = REG_BUS_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              stall_req_if,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_req_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYC);

  arb_state_e state_reg, state_next;

  logic              bus_req_reg, bus_we_reg, bus_err_reg;
  logic [3:0]        bus_sel_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] bus_wdata_reg;
  logic              if_ack_reg, mem_ack_reg;
  logic [DATA_W-1:0] if_rdata_reg, mem_rdata_reg;

  logic busy, grant_mem, grant_if, done, abort, mem_finish, if_finish;
  logic to_en, to_clr, to_hit;

  bus_timeout_cnt u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (to_clr),
    .en    (to_en),
    .limit (TIMEOUT_LIMIT),
    .hit   (to_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ARB_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: grant from IDLE, finish on ack or timeout, divert a flushed fetch.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (grant_mem)     state_next = ARB_MEM_BUSY;
        else if (grant_if) state_next = ARB_IF_BUSY;
      end
      ARB_IF_BUSY: begin
        if (done || abort) state_next = ARB_IDLE;
        else if (flush)    state_next = ARB_IF_DROP;
      end
      default: begin
        if (done || abort) state_next = ARB_IDLE;
      end
    endcase
  end

  // Decode of grant/finish events and the combinational stall requests;
  // the ~ack terms stop a master being regranted in its own ack cycle.
  always_comb begin
    busy          = (state_reg != ARB_IDLE);
    grant_mem     = (state_reg == ARB_IDLE) && mem_req && !mem_ack_reg;
    grant_if      = (state_reg == ARB_IDLE) && !grant_mem && if_req && !if_ack_reg && !flush;
    done          = busy && bus_ack;
    to_en         = busy && !bus_ack;
    abort         = to_hit;
    to_clr        = !to_en || to_hit;
    mem_finish    = (state_reg == ARB_MEM_BUSY) && (done || abort);
    if_finish     = (state_reg == ARB_IF_BUSY) && (done || abort) && !flush;
    // Stalls are forced low while reset is asserted, like every other output.
    stall_req_mem = rst && mem_req && !mem_ack_reg;
    stall_req_if  = rst && if_req && !if_ack_reg && !flush;
  end

  // Bus request/fields latched on grant; acks, read data and error pulses on finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_sel_reg   <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      if_ack_reg  <= 1'b0;
      mem_ack_reg <= 1'b0;
      bus_err_reg <= abort;
      if (grant_mem) begin
        bus_req_reg   <= 1'b1;
        bus_we_reg    <= mem_we;
        bus_sel_reg   <= mem_sel;
        bus_addr_reg  <= mem_addr;
        bus_wdata_reg <= mem_wdata;
      end else if (grant_if) begin
        bus_req_reg   <= 1'b1;
        bus_we_reg    <= 1'b0;
        bus_sel_reg   <= BUS_SEL_ALL;
        bus_addr_reg  <= if_addr;
        bus_wdata_reg <= '0;
      end else if (done || abort) begin
        bus_req_reg <= 1'b0;
      end
      if (mem_finish) begin
        mem_ack_reg   <= 1'b1;
        mem_rdata_reg <= (done && !bus_we_reg) ? bus_rdata : '0;
      end
      if (if_finish) begin
        if_ack_reg   <= 1'b1;
        if_rdata_reg <= done ? bus_rdata : '0;
      end
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_sel   = bus_sel_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_err   = bus_err_reg;
  assign if_ack    = if_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_ack   = mem_ack_reg;
  assign mem_rdata = mem_rdata_reg;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one single-ported memory bus between two masters: instruction fetch (IF, read-only) and data access (MEM stage, load/store).
- Sequences each bus transaction with a req/ack handshake and tolerates variable slave latency.
- Feeds per-master stall requests to ctrl so the pipeline freezes while a master waits.
- Sits between pc_reg/if_id and the memory stage on the master side, and the external memory on the slave side.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYC, 255, cycles without bus_ack before abort (0 disables; max 255)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-low reset
if_req  in  1  IF read request, held until if_ack
if_addr  in  ADDR_W  IF address
flush  in  1  discard the outstanding/pending IF request (branch redirect)
if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse to IF
stall_req_if  out  1  IF waiting, to ctrl
mem_req  in  1  MEM request, held until mem_ack
mem_we  in  1  1=store, 0=load
mem_sel  in  4  byte enables
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid while mem_ack=1
mem_ack  out  1  one-cycle completion pulse to MEM
stall_req_mem  out  1  MEM waiting, to ctrl
bus_req  out  1  slave request, registered
bus_we  out  1  registered
bus_sel  out  4  registered (4'b1111 for IF)
bus_addr  out  ADDR_W  registered
bus_wdata  out  DATA_W  registered
bus_rdata  in  DATA_W  slave read data, valid with bus_ack
bus_ack  in  1  one-cycle slave completion
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0; bus_req drops immediately even mid-transaction.
- States: IDLE, MEM_BUSY, IF_BUSY, IF_DROP.
- IDLE arbitration, fixed priority MEM > IF:
  - mem_req & ~mem_ack -> MEM_BUSY.
  - else if_req & ~if_ack & ~flush -> IF_BUSY.
  - The ~ack qualifiers prevent regranting a master in its own ack cycle.
- On grant: latch addr/we/sel/wdata into bus registers; bus_req=1 from the next cycle.
- Bus fields stay stable while bus_req=1.
- Completion (bus_ack sampled 1 in a BUSY state), at that edge:
  - bus_req<=0.
  - Owner's rdata<=bus_rdata (0 for stores); owner's ack<=1 for exactly one cycle.
  - State -> IDLE; counter cleared.
- Latency: zero-wait slave gives request in cycle 0, bus_req in cycle 1, ack in cycle 2. Back-to-back grants are possible from the ack cycle for the other master.
- flush:
  - In IF_BUSY: state -> IF_DROP. The bus transaction completes normally on bus_ack, but if_ack stays 0 and if_rdata is unchanged; then IDLE.
  - In IDLE: blocks IF grant that cycle. No effect on MEM.
- Timeout: counter increments each BUSY/IF_DROP cycle without bus_ack. When it reaches TIMEOUT_CYC:
  - bus_req<=0 and bus_err pulses one cycle.
  - Owner ack pulses with rdata=0 (no ack in IF_DROP).
  - State -> IDLE.
  - bus_ack arriving in the same cycle as the limit wins; completion is normal, no bus_err.
- Stall outputs (combinational):
  - stall_req_mem = mem_req & ~mem_ack.
  - stall_req_if = if_req & ~if_ack & ~flush.
- A late bus_ack arriving in IDLE is ignored.

Decomposition:
- Shared defines file gets the arbiter state encodings (2-bit) and BusSelAll (4'b1111). Reuse the existing RegBus/InstAddrBus widths.
- One sub-module is natural: bus_timeout_cnt (8-bit counter with clear/enable/limit-hit output).
- FSM and datapath registers stay in bus_arbiter.

Test Plan:
- Single IF read, zero-wait slave: if_req@0 addr 0x100, bus_ack@1 rdata 0x24020005 -> bus_req high cycle 1 only, if_ack@2 with if_rdata=0x24020005, stall_req_if high cycles 0-1.
- Simultaneous if_req and mem_req (store 0xDEADBEEF to 0x200, sel 4'b0011), slave 3-wait -> MEM granted first with bus_we=1, sel=0011; IF granted in the mem_ack cycle; each ack exactly once.
- flush one cycle into an IF_BUSY fetch, slave acks 2 cycles later -> no if_ack, if_rdata unchanged, bus_req drops at ack, next IF request then served normally.
- Slave never acks, TIMEOUT_CYC=4 -> bus_req low after 4 busy cycles, bus_err and mem_ack pulse together, mem_rdata=0; bus_ack arriving on the limit cycle gives a normal ack with no bus_err.
- Reset asserted mid MEM_BUSY -> bus_req, acks and stalls go 0 asynchronously; after release a held mem_req is regranted from IDLE.
